// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - timestep sequencer for the LSTM cell with hidden-state feedback
// Optional macro LSTM_SEQ_ALL_STEPS_EN: emit every step instead of only the final one.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CH         = 4,
  parameter int MAX_T      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CH*DATA_WIDTH-1:0]      in_data,
  input  logic                          in_last,
  output logic                          cell_start,
  output logic [CH*DATA_WIDTH-1:0]      cell_x,
  output logic [CH*DATA_WIDTH-1:0]      cell_y_in,
  input  logic                          cell_finished,
  input  logic [CH*DATA_WIDTH-1:0]      cell_y_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH*DATA_WIDTH-1:0]      out_data,
  output logic                          out_last,
  output logic [$clog2(MAX_T+1)-1:0]    step_cnt,
  output logic                          err_timeout,
  output logic                          seq_ovf
);

  localparam int VW = CH * DATA_WIDTH;
  localparam int SW = $clog2(MAX_T + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] LAST_STEP = SW'(MAX_T);
  // WAIT lasts TIMEOUT-1 cycles; the final one still honours cell_finished.
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t          state;
  logic [VW-1:0]   x_reg;
  logic [VW-1:0]   h_reg;
  logic            last_reg;
  logic            first_flag;
  logic [TW-1:0]   tmo_cnt;
  logic            ovf_hit;
  logic            last_next;
  logic            emit_go;

  assign ovf_hit   = ((step_cnt + SW'(1)) == LAST_STEP) && !last_reg;
  assign last_next = last_reg | ovf_hit;

`ifdef LSTM_SEQ_ALL_STEPS_EN
  assign emit_go = 1'b1;
`else
  assign emit_go = last_next;
`endif

  assign in_ready  = (state == S_IDLE) && !rst;
  assign cell_x    = x_reg;
  assign cell_y_in = h_reg;
  assign out_data  = h_reg;
  assign out_last  = last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      x_reg       <= '0;
      h_reg       <= '0;
      last_reg    <= 1'b0;
      first_flag  <= 1'b1;
      tmo_cnt     <= '0;
      step_cnt    <= '0;
      cell_start  <= 1'b0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      seq_ovf     <= 1'b0;
    end else begin
      cell_start  <= 1'b0;
      err_timeout <= 1'b0;
      seq_ovf     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg    <= in_data;
            last_reg <= in_last;
            if (first_flag) begin
              h_reg      <= '0;
              first_flag <= 1'b0;
            end
            cell_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (cell_finished) begin
            h_reg    <= cell_y_out;
            step_cnt <= step_cnt + SW'(1);
            // Hitting MAX_T without in_last closes the sequence here.
            if (ovf_hit) begin
              seq_ovf  <= 1'b1;
              last_reg <= 1'b1;
            end
            if (emit_go) begin
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              state <= S_IDLE;
            end
          end else if (tmo_cnt == TMO_LIMIT) begin
            err_timeout <= 1'b1;
            first_flag  <= 1'b1;
            step_cnt    <= '0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            if (last_reg) begin
              first_flag <= 1'b1;
              step_cnt   <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - randomized bench for lstm_seq_ctrl with a sequence-level reference model
module tb_lstm_seq_ctrl;

  localparam int DW      = 8;
  localparam int CH      = 4;
  localparam int MAX_T   = 2;
  localparam int TIMEOUT = 16;
  localparam int VW      = DW * CH;
`ifdef LSTM_SEQ_ALL_STEPS_EN
  localparam bit ALL_STEPS = 1'b1;
`else
  localparam bit ALL_STEPS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          cell_start;
  logic [VW-1:0] cell_x;
  logic [VW-1:0] cell_y_in;
  logic          cell_finished = 1'b0;
  logic [VW-1:0] cell_y_out = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          out_last;
  logic [1:0]    step_cnt;
  logic          err_timeout;
  logic          seq_ovf;

  lstm_seq_ctrl #(
    .DATA_WIDTH(DW), .CH(CH), .MAX_T(MAX_T), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cell_start(cell_start), .cell_x(cell_x), .cell_y_in(cell_y_in),
    .cell_finished(cell_finished), .cell_y_out(cell_y_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .step_cnt(step_cnt), .err_timeout(err_timeout), .seq_ovf(seq_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [VW-1:0] exp_yin_q[$];
  logic [VW-1:0] exp_x_q[$];
  logic [VW-1:0] exp_out_q[$];
  bit            exp_last_q[$];
  int ovf_seen = 0, tmo_seen = 0, exp_ovf = 0, exp_tmo = 0;
  int start_cyc = 0, tmo_delta = 0;
  bit force_low = 1'b0, hang = 1'b0;
  int lat = 3;

  // Reference model state: running hidden state, sequence start flag, steps so far.
  logic [VW-1:0] m_h = '0;
  bit            m_first = 1'b1;
  int            m_cnt = 0;

  // Cell: y[i] = x[i] + y_in[i] after lat cycles; hang suppresses finished.
  bit            busy = 1'b0;
  int            busy_cnt = 0;
  logic [VW-1:0] res = '0;
  always @(negedge clk) begin
    cell_finished = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          cell_finished = 1'b1;
          cell_y_out    = res;
          busy          = 1'b0;
        end
      end
      if (cell_start && !hang) begin
        busy     = 1'b1;
        busy_cnt = lat;
        for (int i = 0; i < CH; i++)
          res[i*DW +: DW] = cell_x[i*DW +: DW] + cell_y_in[i*DW +: DW];
      end
    end
  end

  always @(negedge clk) begin
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (!rst) begin
      if (out_valid) check_eq("ready_excl", 64'(in_ready), 64'(0));
      if (cell_start) begin
        start_cyc = cyc;
        if (exp_yin_q.size() == 0) begin
          check_eq("start_unexp", 64'(1), 64'(0));
        end else begin
          check_eq("cell_y_in", 64'(cell_y_in), 64'(exp_yin_q.pop_front()));
          check_eq("cell_x", 64'(cell_x), 64'(exp_x_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          check_eq("out_unexp", 64'(1), 64'(0));
        end else begin
          check_eq("out_data", 64'(out_data), 64'(exp_out_q.pop_front()));
          check_eq("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
        end
      end
      if (seq_ovf) ovf_seen++;
      if (err_timeout) begin
        tmo_seen++;
        tmo_delta = cyc - start_cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 cell hangs, 2 reset during WAIT, 3 output back-pressure
  task automatic do_step(input logic [VW-1:0] x, input bit last, input int mode, input int l);
    logic [VW-1:0] yin;
    logic [VW-1:0] h;
    bit ovf, is_last;
    int n, t0;
    n = 0;
    while (!in_ready && n < 400) begin tick(); n++; end
    check_eq("in_ready_wait", 64'(in_ready), 64'(1));
    yin = m_first ? '0 : m_h;
    exp_yin_q.push_back(yin);
    exp_x_q.push_back(x);
    lat       = l;
    hang      = (mode == 1);
    force_low = (mode == 3);
    if (mode == 0 || mode == 3) begin
      for (int i = 0; i < CH; i++) h[i*DW +: DW] = x[i*DW +: DW] + yin[i*DW +: DW];
      m_h = h;
      m_cnt++;
      ovf     = (m_cnt == MAX_T) && !last;
      is_last = last || ovf;
      if (ALL_STEPS || is_last) begin
        exp_out_q.push_back(h);
        exp_last_q.push_back(is_last);
      end
      if (ovf) exp_ovf++;
      if (is_last) begin m_first = 1'b1; m_cnt = 0; end
      else m_first = 1'b0;
    end else begin
      m_first = 1'b1;
      m_cnt   = 0;
      if (mode == 1) exp_tmo++;
    end
    in_valid = 1'b1;
    in_data  = x;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = $urandom_range(0, 1) != 0;
    case (mode)
      1: begin
        t0 = tmo_seen;
        n  = 0;
        while (tmo_seen == t0 && n < 100) begin tick(); n++; end
        check_eq("tmo_fired", 64'(tmo_seen), 64'(t0 + 1));
        check_eq("tmo_delay", 64'(tmo_delta), 64'(TIMEOUT));
        hang = 1'b0;
      end
      2: begin
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", 64'(in_ready), 64'(1));
        check_eq("post_rst_valid", 64'(out_valid), 64'(0));
      end
      3: begin
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check_eq("bp_valid", 64'(out_valid), 64'(1));
        repeat (10) begin
          if (exp_out_q.size() != 0) check_eq("bp_data", 64'(out_data), 64'(exp_out_q[0]));
          check_eq("bp_in_ready", 64'(in_ready), 64'(0));
          check_eq("bp_start", 64'(cell_start), 64'(0));
          check_eq("bp_hold", 64'(out_valid), 64'(1));
          tick();
        end
        force_low = 1'b0;
      end
      default: ;
    endcase
    n = 0;
    while (!in_ready && n < 400) begin tick(); n++; end
    check_eq("done_ready", 64'(in_ready), 64'(1));
    check_eq("step_cnt", 64'(step_cnt), 64'(m_cnt));
    check_eq("ovf_cnt", 64'(ovf_seen), 64'(exp_ovf));
    check_eq("out_pending", 64'(exp_out_q.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] x1, x2;
    int r, mode;
    x1 = 32'hEBF53525;
    x2 = 32'h5729BC2D;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_ready_low", 64'(in_ready), 64'(0));
    rst = 1'b0;
    tick();
    check_eq("reset_in_ready", 64'(in_ready), 64'(1));
    check_eq("reset_out_valid", 64'(out_valid), 64'(0));
    check_eq("reset_step_cnt", 64'(step_cnt), 64'(0));
    check_eq("reset_start", 64'(cell_start), 64'(0));
    check_eq("reset_out_data", 64'(out_data), 64'(0));
    check_eq("reset_y_in", 64'(cell_y_in), 64'(0));

    do_step(x1, 1'b1, 0, 3);
    do_step(x1, 1'b0, 0, 3);
    do_step(x2, 1'b1, 0, 3);
    do_step($urandom, 1'b1, 3, 3);
    do_step($urandom, 1'b1, 1, 3);
    do_step($urandom, 1'b1, 0, TIMEOUT - 1);
    do_step($urandom, 1'b1, 0, 1);
    do_step(x1, 1'b0, 0, 3);
    do_step(x2, 1'b0, 0, 3);
    do_step(x1, 1'b0, 0, 3);
    do_step(x2, 1'b1, 0, 2);
    do_step(x1, 1'b0, 0, 3);
    do_step(x2, 1'b1, 2, 3);
    do_step(x1, 1'b1, 0, 3);

    for (int s = 0; s < 40; s++) begin
      r    = $urandom_range(0, 19);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      do_step($urandom, (mode == 3) || ($urandom_range(0, 2) == 0), mode,
              (mode == 2) ? 3 : $urandom_range(1, TIMEOUT - 1));
    end

    repeat (5) tick();
    check_eq("tmo_total", 64'(tmo_seen), 64'(exp_tmo));
    check_eq("ovf_total", 64'(ovf_seen), 64'(exp_ovf));
    check_eq("yin_q_empty", 64'(exp_yin_q.size()), 64'(0));
    check_eq("out_q_empty", 64'(exp_out_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
